// File: rtl/obi_tcdm_arbiter_pkg.sv
// Shared types and helpers for the OBI-to-TCDM round-robin arbiter.
// The default struct types fix 32-bit address and data with byte strobes.
package obi_tcdm_arbiter_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        user;
    } tcdm_q_t;

    typedef struct packed {
        logic    q_valid;
        tcdm_q_t q;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] data;
    } tcdm_p_t;

    typedef struct packed {
        logic    q_ready;
        logic    p_valid;
        tcdm_p_t p;
    } tcdm_rsp_t;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_tcdm_arbiter_if.sv
// Bundle of the requester-side and TCDM-side signals around the arbiter.
// master drives requests and TCDM responses; slave is the arbiter's view.
interface obi_tcdm_arbiter_if
    import obi_tcdm_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4
);
    obi_req_t  [NumReq-1:0]                  obi_req;
    obi_rsp_t  [NumReq-1:0]                  obi_rsp;
    tcdm_req_t                               tcdm_req;
    tcdm_rsp_t                               tcdm_rsp;
    logic      [$clog2(MaxOutstanding+1)-1:0] outstanding;
    logic                                    rsp_err;

    modport master (
        output obi_req, tcdm_rsp,
        input  obi_rsp, tcdm_req, outstanding, rsp_err
    );

    modport slave (
        input  obi_req, tcdm_rsp,
        output obi_rsp, tcdm_req, outstanding, rsp_err
    );
endinterface

// File: rtl/obi_tcdm_arbiter_idx_fifo.sv
// In-order FIFO of requester indices with synchronous active-low reset.
// The caller must not push when full nor pop when empty.
module obi_tcdm_arbiter_idx_fifo
    import obi_tcdm_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4,
    localparam int unsigned UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);
    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0]  mem_q [Depth];
    logic [Width-1:0]  mem_d [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [UsageW-1:0] count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop_i) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + UsageW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - UsageW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (count_q == UsageW'(Depth));
    assign empty_o = (count_q == '0);
    assign usage_o = count_q;
endmodule

// File: rtl/obi_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM port among NumReq OBI requesters,
// routing each in-order TCDM response back to its issuer via an index FIFO.
module obi_tcdm_arbiter
    import obi_tcdm_arbiter_pkg::*;
#(
    parameter type         obi_req_t      = obi_tcdm_arbiter_pkg::obi_req_t,
    parameter type         obi_rsp_t      = obi_tcdm_arbiter_pkg::obi_rsp_t,
    parameter type         tcdm_req_t     = obi_tcdm_arbiter_pkg::tcdm_req_t,
    parameter type         tcdm_rsp_t     = obi_tcdm_arbiter_pkg::tcdm_rsp_t,
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned UsageW        = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  obi_req_t  [NumReq-1:0]  obi_req_i,
    output obi_rsp_t  [NumReq-1:0]  obi_rsp_o,
    output tcdm_req_t               tcdm_req_o,
    input  tcdm_rsp_t               tcdm_rsp_i,
    output logic [UsageW-1:0]       outstanding_o,
    output logic                    rsp_err_o
);
    localparam int unsigned IdxW = idx_width(NumReq);
    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_q, rr_d;
    logic lock_q, lock_d;
    idx_t lock_idx_q, lock_idx_d;

    idx_t winner;
    logic any_req, q_valid, hs;
    logic fifo_full, fifo_empty, pop;
    idx_t head;

    // First requester at or after rr_q wins; an unaccepted request stays locked.
    always_comb begin
        winner  = rr_q;
        any_req = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (obi_req_i[(int'(rr_q) + i) % NumReq].req) begin
                winner  = idx_t'((int'(rr_q) + i) % NumReq);
                any_req = 1'b1;
            end
        end
        if (lock_q) begin
            winner = lock_idx_q;
        end
    end

    // Handshake: a TCDM request transfers in a cycle where q_valid and
    // q_ready are both high; q_valid never waits on q_ready, and once raised
    // the request is held stable through the lock until it transfers.
    assign q_valid = rst_ni && (any_req || lock_q) && !fifo_full;
    assign hs      = q_valid && tcdm_rsp_i.q_ready;
    assign pop     = rst_ni && tcdm_rsp_i.p_valid && !fifo_empty;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            rr_d   = (int'(winner) == NumReq - 1) ? '0 : winner + idx_t'(1);
            lock_d = 1'b0;
        end else if (q_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
        if (NumReq == 1) begin
            rr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        tcdm_req_o         = '0;
        tcdm_req_o.q_valid = q_valid;
        tcdm_req_o.q.addr  = obi_req_i[winner].a.addr;
        tcdm_req_o.q.write = obi_req_i[winner].a.we;
        tcdm_req_o.q.data  = obi_req_i[winner].a.wdata;
        tcdm_req_o.q.strb  = obi_req_i[winner].a.be;
        tcdm_req_o.q.amo   = AMONone;
        tcdm_req_o.q.user  = '0;
    end

    always_comb begin
        obi_rsp_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            obi_rsp_o[i].gnt     = hs && (winner == idx_t'(i));
            obi_rsp_o[i].rvalid  = pop && (head == idx_t'(i));
            obi_rsp_o[i].r.rdata = tcdm_rsp_i.p.data;
        end
    end

    assign rsp_err_o = rst_ni && tcdm_rsp_i.p_valid && fifo_empty;

    obi_tcdm_arbiter_idx_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (outstanding_o)
    );
endmodule

// File: tb/tb_obi_tcdm_arbiter.sv
// Directed bench for obi_tcdm_arbiter with two requesters and a two-deep
// index FIFO; TCDM responses are driven by hand from the bench.
module tb_obi_tcdm_arbiter;
    import obi_tcdm_arbiter_pkg::*;

    localparam int unsigned NumReq = 2;
    localparam int unsigned MaxOut = 2;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    obi_tcdm_arbiter_if #(.NumReq(NumReq), .MaxOutstanding(MaxOut)) bus ();

    obi_tcdm_arbiter #(
        .NumReq         (NumReq),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .obi_req_i     (bus.obi_req),
        .obi_rsp_o     (bus.obi_rsp),
        .tcdm_req_o    (bus.tcdm_req),
        .tcdm_rsp_i    (bus.tcdm_rsp),
        .outstanding_o (bus.outstanding),
        .rsp_err_o     (bus.rsp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic [31:0] addr);
        bus.obi_req[i].req     = r;
        bus.obi_req[i].a.addr  = addr;
        bus.obi_req[i].a.we    = 1'b0;
        bus.obi_req[i].a.wdata = 32'h0;
        bus.obi_req[i].a.be    = 4'hF;
    endtask

    task automatic set_rsp(input logic qr, input logic pv, input logic [31:0] d);
        bus.tcdm_rsp.q_ready = qr;
        bus.tcdm_rsp.p_valid = pv;
        bus.tcdm_rsp.p.data  = d;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0);
        set_rsp(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] rsp_tbl [4];
    logic [31:0] exp_d;

    initial begin
        rsp_tbl[0] = 32'hA0A0_0200;
        rsp_tbl[1] = 32'hB1B1_0300;
        rsp_tbl[2] = 32'hA0A0_0201;
        rsp_tbl[3] = 32'hB1B1_0301;

        // reset: outputs forced low even with live inputs
        rst_n = 1'b0;
        idle();
        set_req(0, 1'b1, 32'h10);
        set_rsp(1'b1, 1'b1, 32'h1);
        settle();
        check_eq("rst_q_valid", 32'(bus.tcdm_req.q_valid), 32'd0);
        check_eq("rst_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd0);
        check_eq("rst_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();
        tick();
        idle();
        settle();
        check_eq("rst_outstanding", 32'(bus.outstanding), 32'd0);
        rst_n = 1'b1;
        tick();

        // single requester read of 0x100
        set_req(0, 1'b1, 32'h100);
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t1_q_valid", 32'(bus.tcdm_req.q_valid), 32'd1);
        check_eq("t1_addr", bus.tcdm_req.q.addr, 32'h100);
        check_eq("t1_write", 32'(bus.tcdm_req.q.write), 32'd0);
        check_eq("t1_amo", 32'(bus.tcdm_req.q.amo), 32'(AMONone));
        check_eq("t1_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        check_eq("t1_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd0);
        tick();
        idle();
        set_rsp(1'b1, 1'b1, 32'hDEAD_BEEF);
        settle();
        check_eq("t1_outstanding", 32'(bus.outstanding), 32'd1);
        check_eq("t1_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd1);
        check_eq("t1_rdata0", bus.obi_rsp[0].r.rdata, 32'hDEAD_BEEF);
        check_eq("t1_rvalid1", 32'(bus.obi_rsp[1].rvalid), 32'd0);
        check_eq("t1_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();
        idle();
        settle();
        check_eq("t1_drained", 32'(bus.outstanding), 32'd0);

        // two requesters held: grants alternate 0,1,0,1 from a fresh pointer
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(rsp_tbl[k]);
        for (int k = 0; k < 5; k++) begin
            set_req(0, k < 4, 32'h200 + 32'(k / 2));
            set_req(1, k < 4, 32'h300 + 32'(k / 2));
            set_rsp(1'b1, k > 0, (k > 0) ? rsp_tbl[(k + 3) % 4] : 32'h0);
            settle();
            if (k < 4) begin
                check_eq($sformatf("t2_gnt_win_%0d", k), 32'(bus.obi_rsp[k % 2].gnt), 32'd1);
                check_eq($sformatf("t2_gnt_lose_%0d", k), 32'(bus.obi_rsp[1 - k % 2].gnt), 32'd0);
                check_eq($sformatf("t2_addr_%0d", k), bus.tcdm_req.q.addr,
                         ((k % 2) == 1 ? 32'h300 : 32'h200) + 32'(k / 2));
            end
            if (k > 0) begin
                exp_d = exp_q.pop_front();
                check_eq($sformatf("t2_rvalid_%0d", k), 32'(bus.obi_rsp[(k - 1) % 2].rvalid), 32'd1);
                check_eq($sformatf("t2_rdata_%0d", k), bus.obi_rsp[(k - 1) % 2].r.rdata, exp_d);
                check_eq($sformatf("t2_rvalid_other_%0d", k), 32'(bus.obi_rsp[k % 2].rvalid), 32'd0);
            end
            tick();
        end
        idle();
        settle();
        check_eq("t2_drained", 32'(bus.outstanding), 32'd0);

        // move the pointer to 1 so the lock is what keeps req0 selected
        set_req(0, 1'b1, 32'h40);
        set_rsp(1'b1, 1'b0, 32'h0);
        tick();
        idle();
        set_rsp(1'b0, 1'b1, 32'h0);
        tick();

        // q_ready low for three cycles; req1 rises in the third
        idle();
        set_req(0, 1'b1, 32'h400);
        settle();
        check_eq("t3_c0_q_valid", 32'(bus.tcdm_req.q_valid), 32'd1);
        check_eq("t3_c0_addr", bus.tcdm_req.q.addr, 32'h400);
        check_eq("t3_c0_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd0);
        tick();
        settle();
        check_eq("t3_c1_addr", bus.tcdm_req.q.addr, 32'h400);
        tick();
        set_req(1, 1'b1, 32'h500);
        settle();
        check_eq("t3_c2_addr", bus.tcdm_req.q.addr, 32'h400);
        check_eq("t3_c2_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd0);
        tick();
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t3_c3_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        check_eq("t3_c3_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd0);
        check_eq("t3_c3_addr", bus.tcdm_req.q.addr, 32'h400);
        tick();
        set_req(0, 1'b0, 32'h0);
        set_rsp(1'b1, 1'b1, 32'h0000_0400);
        settle();
        check_eq("t3_c4_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd1);
        check_eq("t3_c4_addr", bus.tcdm_req.q.addr, 32'h500);
        check_eq("t3_c4_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd1);
        tick();
        idle();
        set_rsp(1'b0, 1'b1, 32'h0000_0500);
        settle();
        check_eq("t3_c5_outstanding", 32'(bus.outstanding), 32'd1);
        check_eq("t3_c5_rvalid1", 32'(bus.obi_rsp[1].rvalid), 32'd1);
        check_eq("t3_c5_rdata1", bus.obi_rsp[1].r.rdata, 32'h0000_0500);
        check_eq("t3_c5_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd0);
        tick();

        // FIFO full with responses withheld; a pop frees a slot one cycle later
        idle();
        set_req(0, 1'b1, 32'h600);
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t4_c0_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        tick();
        settle();
        check_eq("t4_c1_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        tick();
        settle();
        check_eq("t4_c2_outstanding", 32'(bus.outstanding), 32'd2);
        check_eq("t4_c2_q_valid", 32'(bus.tcdm_req.q_valid), 32'd0);
        check_eq("t4_c2_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd0);
        tick();
        set_rsp(1'b1, 1'b1, 32'h6666_0000);
        settle();
        check_eq("t4_c3_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd1);
        check_eq("t4_c3_q_valid", 32'(bus.tcdm_req.q_valid), 32'd0);
        check_eq("t4_c3_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd0);
        tick();
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t4_c4_outstanding", 32'(bus.outstanding), 32'd1);
        check_eq("t4_c4_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        tick();
        idle();
        set_rsp(1'b0, 1'b1, 32'h6666_0001);
        settle();
        check_eq("t4_c5_outstanding", 32'(bus.outstanding), 32'd2);
        tick();
        settle();
        check_eq("t4_c6_outstanding", 32'(bus.outstanding), 32'd1);
        tick();
        idle();
        settle();
        check_eq("t4_drained", 32'(bus.outstanding), 32'd0);

        // response with an empty FIFO is dropped
        set_rsp(1'b0, 1'b1, 32'hBAD0_0000);
        settle();
        check_eq("t5_rsp_err", 32'(bus.rsp_err), 32'd1);
        check_eq("t5_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd0);
        check_eq("t5_rvalid1", 32'(bus.obi_rsp[1].rvalid), 32'd0);
        tick();
        idle();
        settle();
        check_eq("t5_rsp_err_clear", 32'(bus.rsp_err), 32'd0);
        check_eq("t5_outstanding", 32'(bus.outstanding), 32'd0);
        tick();

        // reset with two in flight and the pointer at 1
        set_req(1, 1'b1, 32'h700);
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t6_pre_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd1);
        tick();
        idle();
        set_req(0, 1'b1, 32'h800);
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t6_pre_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        tick();
        idle();
        settle();
        check_eq("t6_pre_outstanding", 32'(bus.outstanding), 32'd2);
        do_reset();
        set_rsp(1'b0, 1'b1, 32'h7777_0000);
        settle();
        check_eq("t6_outstanding", 32'(bus.outstanding), 32'd0);
        check_eq("t6_late_err0", 32'(bus.rsp_err), 32'd1);
        check_eq("t6_late_rvalid1", 32'(bus.obi_rsp[1].rvalid), 32'd0);
        tick();
        settle();
        check_eq("t6_late_err1", 32'(bus.rsp_err), 32'd1);
        check_eq("t6_late_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd0);
        tick();
        idle();
        set_req(0, 1'b1, 32'h900);
        set_req(1, 1'b1, 32'hA00);
        set_rsp(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t6_gnt0", 32'(bus.obi_rsp[0].gnt), 32'd1);
        check_eq("t6_gnt1", 32'(bus.obi_rsp[1].gnt), 32'd0);
        check_eq("t6_addr", bus.tcdm_req.q.addr, 32'h900);
        tick();
        idle();
        set_rsp(1'b0, 1'b1, 32'h9999_0000);
        settle();
        check_eq("t6_rvalid0", 32'(bus.obi_rsp[0].rvalid), 32'd1);
        check_eq("t6_rdata0", bus.obi_rsp[0].r.rdata, 32'h9999_0000);
        check_eq("t6_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();
        idle();
        settle();
        check_eq("t6_drained", 32'(bus.outstanding), 32'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/obi_tcdm_arbiter.md
# obi_tcdm_arbiter

Shares one TCDM port between `NumReq` OBI requesters. It performs round-robin arbitration on the request channel and keeps an in-order index FIFO so each TCDM response returns to the requester that issued it. It sits between several core-side or accelerator-side OBI masters and a single TCDM interconnect port, in place of one-to-one OBI/TCDM conversion per master.

## Interface

- `obi_req_t`, default `logic`: OBI request struct with `req`, `a.addr`, `a.we`, `a.wdata`, `a.be`.
- `obi_rsp_t`, default `logic`: OBI response struct with `gnt`, `rvalid`, `r.rdata`, `r.rid`, `r.err`, `r.r_optional`.
- `tcdm_req_t`, default `logic`: TCDM request struct with `q_valid` and `q{addr,write,amo,data,strb,user}`.
- `tcdm_rsp_t`, default `logic`: TCDM response struct with `q_ready`, `p_valid`, `p.data`.
- `NumReq`, default 2: number of OBI requesters. Must be ≥1.
- `MaxOutstanding`, default 4: depth of the index FIFO. Must be ≥1.

Ports:

- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset. Synchronous, active-low.
- `obi_req_i`, input, `NumReq` x `obi_req_t`: requester-side requests.
- `obi_rsp_o`, output, `NumReq` x `obi_rsp_t`: requester-side responses.
- `tcdm_req_o`, output, `tcdm_req_t`: shared TCDM request.
- `tcdm_rsp_i`, input, `tcdm_rsp_t`: shared TCDM response.
- `outstanding_o`, output, `$clog2(MaxOutstanding+1)`: current index FIFO fill level.
- `rsp_err_o`, output, 1: pulses when `p_valid` arrives while the FIFO is empty.

## Operation

- Registered state:
  - round-robin pointer `rr_q`, `$clog2(NumReq)` bits;
  - lock flag `lock_q` and locked index `lock_idx_q`;
  - index FIFO of `$clog2(NumReq)`-bit entries, plus its fill count.
- Arbitration:
  - Candidates are requesters with `req=1`.
  - The winner is the first candidate at or after `rr_q`, searching upward with wrap-around.
  - If `lock_q=1`, the winner is `lock_idx_q` regardless of the other requests.
- `tcdm_req_o.q_valid` = (any candidate, or `lock_q`) AND FIFO not full.
- `tcdm_req_o.q` carries the winner's fields:
  - `addr`, `write`←`we`, `data`←`wdata`, `strb`←`be`;
  - `amo`=`AMONone`, `user`='0.
- Handshake: `q_valid & q_ready`. On handshake:
  - `obi_rsp_o[winner].gnt`=1; every other `gnt` is 0;
  - the winner index is pushed into the FIFO;
  - `rr_q` ← winner+1, wrapping to 0 after `NumReq-1`;
  - `lock_q` ← 0.
- If `q_valid=1` and `q_ready=0`: `lock_q` ← 1 and `lock_idx_q` ← winner. This keeps the TCDM request stable until it is accepted. OBI guarantees the locked requester holds `req`.
- FIFO full:
  - `q_valid`=0 and no grants are given.
  - A pop in the same cycle does not enable a push; the push waits one cycle.
  - A held `lock_q` survives the full period.
- Responses: every accepted request produces exactly one `p_valid`, in order. On `p_valid` with the FIFO non-empty:
  - the FIFO head is popped;
  - `obi_rsp_o[head].rvalid`=1 and `r.rdata`=`p.data`;
  - `rid`, `err`, `r_optional` are '0;
  - every other `rvalid` is 0.
- `p_valid` with the FIFO empty: the response is dropped, `rsp_err_o`=1 for that cycle, and state is unchanged.
- Simultaneous push and pop (FIFO not full): fill level is unchanged.
- `NumReq=1`: the pointer is constant 0. Lock behaviour is unchanged.

## Timing

- Request path is combinational from `obi_req_i`/`tcdm_rsp_i.q_ready` to `tcdm_req_o` and `gnt`. This adds zero cycles.
- Response path is combinational from `tcdm_rsp_i.p_valid`/`p.data` to `rvalid`/`rdata`. This adds zero cycles beyond TCDM latency.
- A response may arrive in the cycle after the grant. A same-cycle grant and response for different requests is legal.
- Reset, applied on the clock edge with `rst_ni=0`:
  - `rr_q`=0, `lock_q`=0, FIFO empty, `outstanding_o`=0.
  - While `rst_ni=0`, outputs are forced: `q_valid`=0, all `gnt`=0, all `rvalid`=0, `rsp_err_o`=0.
- Reset mid-operation discards in-flight indices. Responses for them arriving after reset release are dropped with `rsp_err_o`.

## Structure

- Package `obi_tcdm_arbiter_pkg` holds a `idx_width(NumReq)` helper function returning `$clog2(NumReq)`, minimum 1. The index type is declared locally from it.
- Natural sub-module: `obi_tcdm_arbiter_idx_fifo`, a synchronous-reset FIFO with `full`, `empty`, `usage`, `push` and `pop`. It can be reused for other in-order response routing.
- Arbitration, lock, and field mapping live in the top module.

## Test plan

- Single requester, reads with `q_ready=1` and a 1-cycle TCDM response: a read of 0x100 returns `rdata`=0xDEADBEEF on requester 0 only, and `outstanding_o` returns to 0.
- Two requesters with `req` held continuously and `q_ready=1`: grants alternate 0,1,0,1, and each `rvalid` matches its own address data.
- `q_ready`=0 for 3 cycles while req0 is pending, and req1 rises in cycle 2: the TCDM address stays at req0's value, req0 is granted first, then req1.
- `MaxOutstanding`=2 with responses withheld: the third request sees `q_valid`=0 and `outstanding_o`=2. After one `p_valid`, the grant follows one cycle later.
- `p_valid` injected with the FIFO empty: `rsp_err_o` pulses for 1 cycle, no `rvalid` is asserted, and the FIFO count stays 0.
- Reset asserted with 2 outstanding requests: after release, `outstanding_o`=0, `rr_q`=0 (requester 0 wins the first contention), and late responses raise `rsp_err_o`.
